seg_scan_mux: RTL and testbench

//  Time-multiplexed driver for a 4-digit common-anode 7-segment display, downstream of the watch top.

---
 rtl/seg_scan_if.sv | 46 ++++
 rtl/seg_scan_mux.sv | 110 +++++++++++
 tb/tb_seg_scan_mux.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/seg_scan_if.sv
// Purpose : bundles the four digit patterns and the display-side outputs of the scan driver.
// Latency : wiring only, no logic.
// Backpressure: none; the display is a free-running sink with no ready signal.
//
// Ports/signals:
//   seg_seconds_units/tens, seg_minutes_units/tens : DISP-bit active-low patterns (master -> slave)
//   brightness                                     : 4-bit duty level, only with SEG_SCAN_BRIGHTNESS_EN
//   an, seg, digit_sel, frame_tick                 : registered display outputs (slave -> master)
// Modports: master = pattern source / display observer, slave = seg_scan_mux.
interface seg_scan_if #(
    parameter int DISP = 8
);
    logic [DISP-1:0] seg_seconds_units;
    logic [DISP-1:0] seg_seconds_tens;
    logic [DISP-1:0] seg_minutes_units;
    logic [DISP-1:0] seg_minutes_tens;
`ifdef SEG_SCAN_BRIGHTNESS_EN
    logic [3:0]      brightness;
`endif
    logic [3:0]      an;
    logic [DISP-1:0] seg;
    logic [1:0]      digit_sel;
    logic            frame_tick;

`ifdef SEG_SCAN_BRIGHTNESS_EN
    modport master (
        output seg_seconds_units, seg_seconds_tens, seg_minutes_units, seg_minutes_tens,
        output brightness,
        input  an, seg, digit_sel, frame_tick
    );
    modport slave (
        input  seg_seconds_units, seg_seconds_tens, seg_minutes_units, seg_minutes_tens,
        input  brightness,
        output an, seg, digit_sel, frame_tick
    );
`else
    modport master (
        output seg_seconds_units, seg_seconds_tens, seg_minutes_units, seg_minutes_tens,
        input  an, seg, digit_sel, frame_tick
    );
    modport slave (
        input  seg_seconds_units, seg_seconds_tens, seg_minutes_units, seg_minutes_tens,
        output an, seg, digit_sel, frame_tick
    );
`endif
endinterface

// File: rtl/seg_scan_mux.sv
// Purpose : time-multiplexed 4-digit common-anode 7-segment driver with blanking dead time per slot.
// Latency : all outputs registered; they reflect the slot counter value held in the same cycle.
// Backpressure: none; scans continuously, patterns are sampled once per slot on entry to the ON phase.
//
// Ports:
//   clk  : the only clock
//   rst  : synchronous active-high reset
//   bus  : seg_scan_if.slave -- four digit patterns in; an/seg/digit_sel/frame_tick out
// Optional feature: define SEG_SCAN_BRIGHTNESS_EN to add bus.brightness and a 4-bit PWM gate on the anodes.
module seg_scan_mux #(
    parameter int DISP        = 8,
    parameter int REFRESH_DIV = 100000,
    parameter int DEAD_CYCLES = 1000
) (
    input  logic         clk,
    input  logic         rst,
    seg_scan_if.slave    bus
);
    localparam int              KW     = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [KW-1:0]   K_LAST = KW'(REFRESH_DIV - 1);
    localparam logic [KW-1:0]   K_DEAD = KW'(DEAD_CYCLES);

    logic [KW-1:0]   k_q, k_d;
    logic [1:0]      idx_q, idx_d;
    logic [DISP-1:0] pat_q, pat_d;
    logic [3:0]      an_q, an_d;
    logic [DISP-1:0] seg_q, seg_d;
    logic            ft_q, ft_d;
    logic [DISP-1:0] pat_sel;
    logic            anode_en;
`ifdef SEG_SCAN_BRIGHTNESS_EN
    logic [3:0]      pwm_q, pwm_d;
`endif

    // Pattern for the digit that owns the upcoming slot.
    always_comb begin
        pat_sel = bus.seg_seconds_units;
        case (idx_d)
            2'd0: pat_sel = bus.seg_seconds_units;
            2'd1: pat_sel = bus.seg_seconds_tens;
            2'd2: pat_sel = bus.seg_minutes_units;
            2'd3: pat_sel = bus.seg_minutes_tens;
            default: pat_sel = bus.seg_seconds_units;
        endcase
    end

    always_comb begin
        k_d   = k_q + KW'(1);
        idx_d = idx_q;
        ft_d  = 1'b0;
        if (k_q == K_LAST) begin
            k_d   = '0;
            idx_d = idx_q + 2'd1;
            // Only a genuine 3->0 wrap marks a new frame; reset does not.
            ft_d  = (idx_q == 2'd3);
        end

        // Sample once on the edge entering ON; k_d==0 covers a zero dead time.
        pat_d = pat_q;
        if (k_d == K_DEAD) begin
            pat_d = pat_sel;
        end

`ifdef SEG_SCAN_BRIGHTNESS_EN
        pwm_d    = pwm_q + 4'd1;
        anode_en = (pwm_d <= bus.brightness);
`else
        anode_en = 1'b1;
`endif

        an_d  = 4'b1111;
        seg_d = '1;
        if (k_d >= K_DEAD) begin
            seg_d = pat_d;
            if (anode_en) begin
                an_d[idx_d] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            k_q   <= '0;
            idx_q <= '0;
            // Preload digit 0 so a zero-dead-time build lights correctly in the first slot.
            pat_q <= bus.seg_seconds_units;
            an_q  <= 4'b1111;
            seg_q <= '1;
            ft_q  <= 1'b0;
`ifdef SEG_SCAN_BRIGHTNESS_EN
            pwm_q <= '0;
`endif
        end else begin
            k_q   <= k_d;
            idx_q <= idx_d;
            pat_q <= pat_d;
            an_q  <= an_d;
            seg_q <= seg_d;
            ft_q  <= ft_d;
`ifdef SEG_SCAN_BRIGHTNESS_EN
            pwm_q <= pwm_d;
`endif
        end
    end

    assign bus.an         = an_q;
    assign bus.seg        = seg_q;
    assign bus.digit_sel  = idx_q;
    assign bus.frame_tick = ft_q;
endmodule

// File: tb/tb_seg_scan_mux.sv
// Purpose : self-checking bench for seg_scan_mux (REFRESH_DIV=10; DEAD_CYCLES=2 and 0 instances).
// Latency : n/a.
// Backpressure: n/a.
module tb_seg_scan_mux;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    seg_scan_if #(.DISP(8)) bus_a ();
    seg_scan_if #(.DISP(8)) bus_b ();

    seg_scan_mux #(.DISP(8), .REFRESH_DIV(10), .DEAD_CYCLES(2)) dut_a (
        .clk (clk), .rst (rst), .bus (bus_a.slave)
    );
    seg_scan_mux #(.DISP(8), .REFRESH_DIV(10), .DEAD_CYCLES(0)) dut_b (
        .clk (clk), .rst (rst), .bus (bus_b.slave)
    );

    typedef struct {
        int         cyc;
        logic [3:0] an;
        logic [7:0] seg;
        logic [1:0] ds;
        logic       ft;
        logic [3:0] an_b;
        logic [7:0] seg_b;
    } vec_t;

    vec_t tbl [14];
    int   n_pass  = 0;
    int   n_total = 0;
    int   cyc     = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s @cyc %0d: got %h, expected %h", nm, cyc, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
        cyc++;
    endtask

    task automatic run_to(input int target);
        while (cyc < target) step();
    endtask

    task automatic set_pats(input logic [7:0] su, input logic [7:0] st,
                            input logic [7:0] mu, input logic [7:0] mt);
        bus_a.seg_seconds_units = su; bus_a.seg_seconds_tens = st;
        bus_a.seg_minutes_units = mu; bus_a.seg_minutes_tens = mt;
        bus_b.seg_seconds_units = su; bus_b.seg_seconds_tens = st;
        bus_b.seg_minutes_units = mu; bus_b.seg_minutes_tens = mt;
    endtask

    // Holds reset for n edges, releases it at a falling edge; cyc 0 is the first cycle after release.
    task automatic do_reset(input int n);
        rst = 1'b1;
        repeat (n) step();
        rst = 1'b0;
        cyc = 0;
    endtask

    initial begin
        int viol_a, viol_b, ft_cnt, last_act, blank_run, zeros, act_cnt, exp_cnt;

        tbl[0]  = '{1,  4'hF, 8'hFF, 2'd0, 1'b0, 4'hE, 8'hC0};
        tbl[1]  = '{2,  4'hE, 8'hC0, 2'd0, 1'b0, 4'hE, 8'hC0};
        tbl[2]  = '{9,  4'hE, 8'hC0, 2'd0, 1'b0, 4'hE, 8'hC0};
        tbl[3]  = '{10, 4'hF, 8'hFF, 2'd1, 1'b0, 4'hD, 8'hF9};
        tbl[4]  = '{11, 4'hF, 8'hFF, 2'd1, 1'b0, 4'hD, 8'hF9};
        tbl[5]  = '{12, 4'hD, 8'hF9, 2'd1, 1'b0, 4'hD, 8'hF9};
        tbl[6]  = '{20, 4'hF, 8'hFF, 2'd2, 1'b0, 4'hB, 8'hA4};
        tbl[7]  = '{22, 4'hB, 8'hA4, 2'd2, 1'b0, 4'hB, 8'hA4};
        tbl[8]  = '{30, 4'hF, 8'hFF, 2'd3, 1'b0, 4'h7, 8'hB0};
        tbl[9]  = '{32, 4'h7, 8'hB0, 2'd3, 1'b0, 4'h7, 8'hB0};
        tbl[10] = '{39, 4'h7, 8'hB0, 2'd3, 1'b0, 4'h7, 8'hB0};
        tbl[11] = '{40, 4'hF, 8'hFF, 2'd0, 1'b1, 4'hE, 8'hC0};
        tbl[12] = '{41, 4'hF, 8'hFF, 2'd0, 1'b0, 4'hE, 8'hC0};
        tbl[13] = '{42, 4'hE, 8'hC0, 2'd0, 1'b0, 4'hE, 8'hC0};

        set_pats(8'hC0, 8'hF9, 8'hA4, 8'hB0);
`ifdef SEG_SCAN_BRIGHTNESS_EN
        bus_a.brightness = 4'd15;
        bus_b.brightness = 4'd15;
`endif

        // Test 1: reset in the middle of a scan.
        do_reset(2);
        run_to(17);
        @(negedge clk);
        rst = 1'b1;
        repeat (3) step();
        chk("rst_an",  32'(bus_a.an), 32'hF);
        chk("rst_seg", 32'(bus_a.seg), 32'hFF);
        chk("rst_ds",  32'(bus_a.digit_sel), 32'd0);
        chk("rst_ft",  32'(bus_a.frame_tick), 32'd0);
        chk("rst_an_b", 32'(bus_b.an), 32'hF);
        rst = 1'b0;
        cyc = 0;

        // Tests 2 and 5: scan order, dead time, frame tick, zero-dead-time instance.
        for (int i = 0; i < 14; i++) begin
            run_to(tbl[i].cyc);
            chk("scan_an",  32'(bus_a.an), 32'(tbl[i].an));
            chk("scan_seg", 32'(bus_a.seg), 32'(tbl[i].seg));
            chk("scan_ds",  32'(bus_a.digit_sel), 32'(tbl[i].ds));
            chk("scan_ft",  32'(bus_a.frame_tick), 32'(tbl[i].ft));
            chk("nodead_an",  32'(bus_b.an), 32'(tbl[i].an_b));
            chk("nodead_seg", 32'(bus_b.seg), 32'(tbl[i].seg_b));
        end

        // Test 3: pattern change mid-slot is held off until the digit's next slot.
        run_to(45);
        bus_a.seg_seconds_units = 8'h92;
        run_to(46);
        chk("hold_seg46", 32'(bus_a.seg), 32'hC0);
        run_to(49);
        chk("hold_seg49", 32'(bus_a.seg), 32'hC0);
        chk("hold_an49",  32'(bus_a.an), 32'hE);
        run_to(80);
        chk("frame2_ft", 32'(bus_a.frame_tick), 32'd1);
        run_to(81);
        chk("frame2_ft_off", 32'(bus_a.frame_tick), 32'd0);
        run_to(82);
        chk("new_seg82", 32'(bus_a.seg), 32'h92);
        chk("new_an82",  32'(bus_a.an), 32'hE);

        // Test 4: random patterns over 1000 frames; exclusivity, dead time, frame count.
        do_reset(1);
        viol_a = 0; viol_b = 0; ft_cnt = 0; last_act = -1; blank_run = 0;
        for (int n = 1; n <= 40000; n++) begin
            set_pats(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));
            step();
            if (bus_a.frame_tick) ft_cnt++;
            zeros = $countones(~bus_a.an);
            if (zeros > 1) viol_a++;
            if (zeros == 1) begin
                for (int d = 0; d < 4; d++) begin
                    if (!bus_a.an[d]) begin
                        if (last_act >= 0 && d != last_act && blank_run < 2) viol_a++;
                        last_act = d;
                    end
                end
                blank_run = 0;
            end else begin
                blank_run++;
            end
            if ($countones(~bus_b.an) != 1) viol_b++;
        end
        chk("excl_dead_a", 32'(viol_a), 32'd0);
        chk("excl_b",      32'(viol_b), 32'd0);
        chk("frame_count", 32'(ft_cnt), 32'd1000);

`ifdef SEG_SCAN_BRIGHTNESS_EN
        // Test 6: brightness 3 lights the anode only when pwm (cycle mod 16) <= 3 during ON.
        bus_a.brightness = 4'd3;
        set_pats(8'hC0, 8'hF9, 8'hA4, 8'hB0);
        do_reset(1);
        act_cnt = 0; exp_cnt = 0;
        for (int n = 1; n <= 160; n++) begin
            step();
            if (bus_a.an != 4'hF) act_cnt++;
            if ((n % 10) >= 2 && (n % 16) <= 3) exp_cnt++;
        end
        chk("pwm_active", 32'(act_cnt), 32'(exp_cnt));
`else
        act_cnt = 0; exp_cnt = 0;
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
